// File: rtl/div_const_pkg.sv
// Shared constants and types for the 16/3 quotient remainder checker.
// The result record is packed so the FIFO stores it as one word.
package div_const_pkg;

  localparam int X_W     = 16;
  localparam int Q_W     = 15;
  localparam int DIVISOR = 3;
  localparam int R_W     = $clog2(DIVISOR);
  localparam int DIV_LAT = 2;

  typedef struct packed {
    logic [Q_W-1:0] q;
    logic [R_W-1:0] r;
    logic           err;
  } div_res_t;

  typedef enum logic {
    ST_OK  = 1'b0,
    ST_ERR = 1'b1
  } err_state_t;

endpackage

// File: rtl/div_res_fifo.sv
// Synchronous show-ahead FIFO of checked results.
// While empty, the head presents the most recently popped entry.
module div_res_fifo
  import div_const_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  div_res_t wr_data,
  output div_res_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  div_res_t       mem [DEPTH];
  div_res_t       last_pop;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? last_pop : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_pop <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        last_pop <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/div_16_3_rem_check.sv
// Aligns dividends with divider quotients, checks R = X - 3*Q, and buffers results.
// Optional DIV_CHECK_STATS_EN adds saturating res_cnt/err_cnt counters.
module div_16_3_rem_check
  import div_const_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [X_W-1:0] in_x,
  input  logic [Q_W-1:0] q_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Q_W-1:0] out_q,
  output logic [R_W-1:0] out_r,
  output logic           out_err,
  output logic           err_sticky,
  output logic [X_W-1:0] err_x,
  output logic [Q_W-1:0] err_q,
  output logic           ovf_sticky,
  input  logic           clr_status
`ifdef DIV_CHECK_STATS_EN
  ,
  output logic [15:0]    res_cnt,
  output logic [15:0]    err_cnt
`endif
);

  localparam logic [X_W+1:0] DIV_EXT = (X_W+2)'(DIVISOR);

  logic           pipe_v [DIV_LAT];
  logic [X_W-1:0] pipe_x [DIV_LAT];
  logic           chk_valid;
  logic [X_W-1:0] chk_x;
  logic [X_W+1:0] r_full;
  logic           chk_err;
  div_res_t       chk_res;
  div_res_t       head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;
  logic           drop;
  err_state_t     state;
  err_state_t     state_nxt;
  logic           capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIV_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_x[i] <= '0;
      end
    end else begin
      pipe_v[0] <= in_valid;
      pipe_x[0] <= in_x;
      for (int i = 1; i < DIV_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_x[i] <= pipe_x[i-1];
      end
    end
  end

  assign chk_valid = pipe_v[DIV_LAT-1];
  assign chk_x     = pipe_x[DIV_LAT-1];

  // Two's-complement remainder in X_W+2 bits; negative values have the top bit set.
  assign r_full  = {2'b00, chk_x} - ({{(X_W+2-Q_W){1'b0}}, q_in} * DIV_EXT);
  assign chk_err = r_full[X_W+1] | (r_full >= DIV_EXT);
  assign chk_res = '{q: q_in, r: r_full[R_W-1:0], err: chk_err};

  // Output handshake: an entry transfers on every clk edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready.
  assign pop  = out_valid & out_ready;
  assign drop = chk_valid & fifo_full & ~pop;

  div_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (chk_valid),
    .pop     (pop),
    .wr_data (chk_res),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_q     = head.q;
  assign out_r     = head.r;
  assign out_err   = head.err;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_OK;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OK:  if (chk_valid && chk_err) state_nxt = ST_ERR;
      ST_ERR: if (clr_status) state_nxt = (chk_valid && chk_err) ? ST_ERR : ST_OK;
      default: state_nxt = ST_OK;
    endcase
  end

  always_comb begin
    err_sticky = (state == ST_ERR);
  end

  // A clear coinciding with a new error restarts the capture with that error.
  assign capture = chk_valid & chk_err & ((state == ST_OK) | clr_status);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_x      <= '0;
      err_q      <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (capture) begin
        err_x <= chk_x;
        err_q <= q_in;
      end
      if (drop)            ovf_sticky <= 1'b1;
      else if (clr_status) ovf_sticky <= 1'b0;
    end
  end

`ifdef DIV_CHECK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      res_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (chk_valid && res_cnt != 16'hFFFF) res_cnt <= res_cnt + 16'd1;
      if (chk_valid && chk_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_div_16_3_rem_check.sv
// Directed bench for div_16_3_rem_check; models the 2-cycle divider by delaying q_in.
// Optional DIV_CHECK_STATS_EN also checks the statistics counters.
module tb_div_16_3_rem_check;
  import div_const_pkg::*;

  localparam int EW = Q_W + R_W + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic [X_W-1:0] in_x = '0;
  logic [Q_W-1:0] q_in = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [Q_W-1:0] out_q;
  logic [R_W-1:0] out_r;
  logic           out_err;
  logic           err_sticky;
  logic [X_W-1:0] err_x;
  logic [Q_W-1:0] err_q;
  logic           ovf_sticky;
  logic           clr_status = 1'b0;
`ifdef DIV_CHECK_STATS_EN
  logic [15:0]    res_cnt;
  logic [15:0]    err_cnt;
`endif

  logic [Q_W-1:0] qd [2];
  logic [EW-1:0]  exp_q [$];
  logic [EW-1:0]  got;
  logic [EW-1:0]  exp_v;
  int checks   = 0;
  int failures = 0;

  div_16_3_rem_check dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .q_in       (q_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_q      (out_q),
    .out_r      (out_r),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .err_x      (err_x),
    .err_q      (err_q),
    .ovf_sticky (ovf_sticky),
    .clr_status (clr_status)
`ifdef DIV_CHECK_STATS_EN
    ,
    .res_cnt    (res_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: apply one cycle of input; q arrives DIV_LAT cycles after its dividend
  task automatic cycle(input logic v, input logic [X_W-1:0] x, input logic [Q_W-1:0] q);
    in_valid = v;
    in_x     = x;
    q_in     = qd[1];
    qd[1]    = qd[0];
    qd[0]    = q;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    checks++;
    if ({out_valid, out_q, out_r, out_err} !== '0) begin
      failures++;
      $display("FAIL reset_head: got v=%0b q=%0d r=%0d e=%0b, expected all 0", out_valid, out_q, out_r, out_err);
    end
    checks++;
    if ({err_sticky, err_x, err_q, ovf_sticky} !== '0) begin
      failures++;
      $display("FAIL reset_status: got es=%0b ex=%0d eq=%0d ovf=%0b, expected all 0", err_sticky, err_x, err_q, ovf_sticky);
    end
  endtask

  task automatic test_basic();
    cycle(1'b1, 16'd100, 15'd33);
    idle(2);
    checks++;
    if ({out_valid, out_q, out_r, out_err} !== {1'b1, 15'd33, 2'd1, 1'b0}) begin
      failures++;
      $display("FAIL basic_100: got v=%0b q=%0d r=%0d e=%0b, expected v=1 q=33 r=1 e=0", out_valid, out_q, out_r, out_err);
    end
    idle(1);
    checks++;
    if ({out_valid, out_q, out_r} !== {1'b0, 15'd33, 2'd1}) begin
      failures++;
      $display("FAIL hold_last: got v=%0b q=%0d r=%0d, expected v=0 q=33 r=1", out_valid, out_q, out_r);
    end
  endtask

  task automatic test_boundary();
    cycle(1'b1, 16'hFFFF, 15'd21845);
    cycle(1'b1, 16'd2, 15'd0);
    idle(1);
    checks++;
    if ({out_valid, out_q, out_r, out_err} !== {1'b1, 15'd21845, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL max_x: got v=%0b q=%0d r=%0d e=%0b, expected v=1 q=21845 r=0 e=0", out_valid, out_q, out_r, out_err);
    end
    idle(1);
    checks++;
    if ({out_valid, out_q, out_r, out_err} !== {1'b1, 15'd0, 2'd2, 1'b0}) begin
      failures++;
      $display("FAIL small_x: got v=%0b q=%0d r=%0d e=%0b, expected v=1 q=0 r=2 e=0", out_valid, out_q, out_r, out_err);
    end
    idle(1);
  endtask

  task automatic test_error();
    cycle(1'b1, 16'd10, 15'd4);
    idle(2);
    checks++;
    if ({out_valid, out_q, out_r, out_err} !== {1'b1, 15'd4, 2'd2, 1'b1}) begin
      failures++;
      $display("FAIL err_head: got v=%0b q=%0d r=%0d e=%0b, expected v=1 q=4 r=2 e=1", out_valid, out_q, out_r, out_err);
    end
    checks++;
    if ({err_sticky, err_x, err_q} !== {1'b1, 16'd10, 15'd4}) begin
      failures++;
      $display("FAIL err_capture: got es=%0b ex=%0d eq=%0d, expected es=1 ex=10 eq=4", err_sticky, err_x, err_q);
    end
    // second bad entry: 7 - 15 = -8, low bits 00
    cycle(1'b1, 16'd7, 15'd5);
    idle(2);
    checks++;
    if ({out_valid, out_q, out_r, out_err, err_x, err_q} !== {1'b1, 15'd5, 2'd0, 1'b1, 16'd10, 15'd4}) begin
      failures++;
      $display("FAIL err_keep: got v=%0b q=%0d r=%0d e=%0b ex=%0d eq=%0d, expected v=1 q=5 r=0 e=1 ex=10 eq=4",
               out_valid, out_q, out_r, out_err, err_x, err_q);
    end
    // clear coinciding with a new error (20 - 21 = -1) recaptures
    cycle(1'b1, 16'd20, 15'd7);
    idle(1);
    clr_status = 1'b1;
    idle(1);
    clr_status = 1'b0;
    checks++;
    if ({err_sticky, err_x, err_q, out_r, out_err} !== {1'b1, 16'd20, 15'd7, 2'd3, 1'b1}) begin
      failures++;
      $display("FAIL clr_with_err: got es=%0b ex=%0d eq=%0d r=%0d e=%0b, expected es=1 ex=20 eq=7 r=3 e=1",
               err_sticky, err_x, err_q, out_r, out_err);
    end
    clr_status = 1'b1;
    idle(1);
    clr_status = 1'b0;
    checks++;
    if (err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL clr_status: got es=%0b, expected 0", err_sticky);
    end
`ifdef DIV_CHECK_STATS_EN
    checks++;
    if ({res_cnt, err_cnt} !== {16'd6, 16'd3}) begin
      failures++;
      $display("FAIL stats: got res=%0d err=%0d, expected res=6 err=3", res_cnt, err_cnt);
    end
`endif
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got   = {out_q, out_r, out_err};
      checks++;
      if (!out_valid || got !== exp_v) begin
        failures++;
        $display("FAIL %s: got v=%0b entry=%h, expected v=1 entry=%h", name, out_valid, got, exp_v);
      end
      idle(1);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_empty: got out_valid=%0b, expected 0", name, out_valid);
    end
  endtask

  task automatic test_overflow();
    logic [Q_W-1:0] q;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      q = (i < 3) ? 15'd10 : 15'd11;
      cycle(1'b1, 16'(30 + i), q);
      if (i < 4) exp_q.push_back({q, 2'(i % 3), 1'b0});
    end
    idle(3);
    checks++;
    if ({out_valid, ovf_sticky} !== 2'b11) begin
      failures++;
      $display("FAIL ovf_set: got v=%0b ovf=%0b, expected v=1 ovf=1", out_valid, ovf_sticky);
    end
    drain("ovf_drain");
    clr_status = 1'b1;
    idle(1);
    clr_status = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr: got ovf=%0b, expected 0", ovf_sticky);
    end
  endtask

  task automatic test_back_to_back();
    logic [Q_W-1:0] q;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q = (i < 2) ? 15'd13 : 15'd14;
      cycle(1'b1, 16'(40 + i), q);
      if (i > 0) exp_q.push_back({q, 2'((40 + i) % 3), 1'b0});
    end
    idle(1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, ovf_sticky} !== 2'b10) begin
      failures++;
      $display("FAIL push_pop_full: got v=%0b ovf=%0b, expected v=1 ovf=0", out_valid, ovf_sticky);
    end
    drain("pp_drain");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    cycle(1'b1, 16'd50, 15'd0);
    for (int i = 1; i < 5; i++) cycle(1'b1, 16'(50 + i), 15'd17);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checks++;
    if ({out_valid, out_q, out_r, out_err, err_sticky, err_x, err_q, ovf_sticky} !== '0) begin
      failures++;
      $display("FAIL reset_mid: got v=%0b q=%0d r=%0d e=%0b es=%0b ex=%0d eq=%0d ovf=%0b, expected all 0",
               out_valid, out_q, out_r, out_err, err_sticky, err_x, err_q, ovf_sticky);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_stale_%0d: got out_valid=%0b, expected 0", i, out_valid);
      end
    end
`ifdef DIV_CHECK_STATS_EN
    checks++;
    if ({res_cnt, err_cnt} !== 32'd0) begin
      failures++;
      $display("FAIL stats_reset: got res=%0d err=%0d, expected 0", res_cnt, err_cnt);
    end
`endif
  endtask

  initial begin
    qd[0] = '0;
    qd[1] = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_error();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
